// File: rtl/fetch_pkg.sv
// Shared constants, occupancy states and address helpers for the IF-stage fetch sequencer.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_STEP = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    STREAM = 2'd1,
    FULL   = 2'd2
  } occ_state_e;

  function automatic logic [XLEN-1:0] wrap_addr(input logic [XLEN-1:0] addr,
                                                input logic [XLEN-1:0] mask);
    return addr & mask;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pc+instr holding register; load takes precedence over clear.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the pc, issues reads to a 1-cycle synchronous imem and presents
// instructions to ID through a valid/stall slot backed by a one-entry skid buffer.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_en,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_instr,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic [XLEN-1:0]  if_instr,
  output logic             misalign_err
);

  localparam logic [XLEN-1:0] PC_MASK = XLEN'(IMEM_BYTES - 1);

  occ_state_e      state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] if_pc_q, if_instr_q;
  logic            misalign_q;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc, skid_instr;
  logic            accept, issue, slot_take, skid_load, skid_clear;

  assign if_valid  = (state_q != EMPTY);
  assign accept    = if_valid & ~stall;
  // A stalled slot with a read landing and an empty skid must not issue: the skid takes that read.
  assign issue     = ~rst & ~redirect & (~skid_valid | accept)
                   & ~(stall & if_valid & inflight_q & ~skid_valid);
  assign slot_take  = ~redirect & (~if_valid | accept);
  assign skid_load  = ~redirect & if_valid & stall & inflight_q;
  assign skid_clear = redirect | (slot_take & skid_valid);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d = wrap_addr({redirect_pc[31:2], 2'b00}, PC_MASK);
    end else if (issue) begin
      pc_d          = wrap_addr(pc_q + INSTR_STEP, PC_MASK);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      if_pc_q    <= 32'd0;
      if_instr_q <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_q | (redirect & (redirect_pc[1:0] != 2'b00));
      if (redirect) begin
        state_q <= EMPTY;
      end else if (slot_take) begin
        if (skid_valid) begin
          state_q    <= STREAM;
          if_pc_q    <= skid_pc;
          if_instr_q <= skid_instr;
        end else if (inflight_q) begin
          state_q    <= STREAM;
          if_pc_q    <= inflight_pc_q;
          if_instr_q <= imem_instr;
        end else begin
          state_q <= EMPTY;
        end
      end else begin
        // Slot is held by a stall here; only a landing read changes occupancy.
        case (state_q)
          STREAM:  state_q <= inflight_q ? FULL : STREAM;
          FULL:    state_q <= FULL;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (inflight_pc_q),
    .instr_i (imem_instr),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign imem_en      = issue;
  assign imem_addr    = pc_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a stream-level model of presented instructions.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;

  logic [31:0] mem [8];
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  // Stream model: cycles since the last reset/redirect, next pc to be presented, sticky flag.
  int          since   = 0;
  logic [31:0] exp_pc  = 32'd0;
  logic        exp_mis = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) rdata <= mem[imem_addr[4:2]];
  end
  assign imem_instr = rdata;

  fetch_controller #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .misalign_err (misalign_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic s, input logic r, input logic [31:0] rpc, input logic rs);
    logic ev;
    @(posedge clk);
    #1;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    rst         = rs;
    @(negedge clk);
    ev = (since >= 2);
    if (rs) begin
      check_eq("rst_valid", 32'(if_valid), 32'd0);
      check_eq("rst_imem_en", 32'(imem_en), 32'd0);
      check_eq("rst_if_pc", if_pc, 32'd0);
      check_eq("rst_misalign", 32'(misalign_err), 32'd0);
      since   = 0;
      exp_pc  = 32'h0000_0000;
      exp_mis = 1'b0;
    end else begin
      check_eq("if_valid", 32'(if_valid), 32'(ev));
      if (ev) begin
        check_eq("if_pc", if_pc, exp_pc);
        check_eq("if_instr", if_instr, mem[exp_pc[4:2]]);
      end
      check_eq("misalign_err", 32'(misalign_err), 32'(exp_mis));
      if (r) check_eq("imem_en_redirect", 32'(imem_en), 32'd0);
      else if (!s) check_eq("imem_en_free", 32'(imem_en), 32'd1);
      if (r) begin
        since  = 0;
        exp_pc = rpc & 32'h0000_001C;
        if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
      end else begin
        if (ev && !s) exp_pc = (exp_pc + 32'd4) & 32'h0000_001F;
        if (since < 2) since++;
      end
    end
  endtask

  initial begin
    logic        s, r, rs;
    logic [31:0] rpc;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;

    // Boot and stream past the wrap point.
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);

    // Fresh boot, then a 3-cycle stall while 8 is presented.
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);

    // Stream at 8, then redirect to 20.
    cycle(1'b0, 1'b1, 32'd8, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, 32'd20, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);

    // Fill the skid with a stall, then redirect to 4 while still stalled.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 32'd4, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);

    // Misaligned target, then reset mid-stream.
    cycle(1'b0, 1'b1, 32'h0000_0017, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      s   = ($urandom % 100) < 35;
      r   = ($urandom % 100) < 6;
      rs  = ($urandom % 1000) < 5;
      rpc = $urandom;
      if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
      if (rs) r = 1'b0;
      cycle(s, r, rpc, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the IF stage. It owns the program counter and drives the synchronous instruction memory's enable and address, which gives one-cycle read latency. It presents fetched instructions to the IF/ID register through a valid/stall handshake. A one-entry skid buffer catches the read already in flight when ID stalls, and a redirect from EX squashes wrong-path fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be word aligned.
- IMEM_BYTES, 32: instruction memory size in bytes; power of two; PC wraps modulo this value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  ID cannot take the presented instruction this cycle.
- redirect  in  1  branch/jump taken; highest priority.
- redirect_pc  in  32  target address; sampled when redirect=1.
- imem_en  out  1  read strobe to instruction memory (combinational).
- imem_addr  out  32  byte address of the read (combinational, equals pc).
- imem_instr  in  32  memory data; valid the cycle after an issue.
- if_valid  out  1  if_pc/if_instr hold a live instruction.
- if_pc  out  32  address of the presented instruction.
- if_instr  out  32  presented instruction word.
- misalign_err  out  1  sticky flag: a redirect target had bits [1:0] nonzero.

## Operation
- Registers:
  - pc
  - inflight, inflight_pc: a read was issued last cycle.
  - output slot: if_valid, if_pc, if_instr.
  - skid: skid_valid, skid_pc, skid_instr.
  - misalign_err.
- Reset values: pc=RESET_PC, all valid and flag registers 0, if_pc/if_instr/skid data 0. imem_en is 0 while rst=1.
- accept = if_valid & ~stall.
- Issue condition: imem_en = ~rst & ~redirect & (~skid_valid | accept) & ~(stall & if_valid & inflight & ~skid_valid). On issue, pc <= (pc+4) mod IMEM_BYTES, inflight <= 1, inflight_pc <= pc. Otherwise pc holds and inflight <= 0.
- Output slot update, when ~redirect and (~if_valid | accept):
  - If skid_valid: load the slot from skid and clear skid.
  - Else if inflight: load the slot from imem_instr and inflight_pc.
  - Else: if_valid <= 0.
- Skid capture: if if_valid & stall & inflight, then {skid_pc, skid_instr} <= {inflight_pc, imem_instr} and skid_valid <= 1.
- Redirect handling:
  - pc <= {redirect_pc[31:2], 2'b00} mod IMEM_BYTES.
  - Clear if_valid, skid_valid and inflight; discard the data on imem_instr.
  - No issue in the redirect cycle. Redirect overrides stall.
  - If redirect_pc[1:0] != 0, set misalign_err; it stays set until reset.
- Occupancy FSM, derived from if_valid and skid_valid:
  - EMPTY: slot empty. Goes to STREAM when data arrives.
  - STREAM: slot valid, skid empty. Goes to FULL on stall with inflight. Goes to EMPTY on accept with nothing arriving.
  - FULL: slot and skid valid. Goes to STREAM on accept.
  - Any state goes to EMPTY on redirect. SKID-full with stall holds everything.
- Every fetched word is presented exactly once, in program order; none are lost or duplicated under any stall pattern.

## Timing
- Boot: first cycle after rst deasserts (C0) issues RESET_PC. imem_instr is valid in C1. if_valid=1 with if_pc=RESET_PC in C2.
- Steady state, no stalls: one instruction per cycle. if_pc increments by 4 each cycle and wraps from IMEM_BYTES-4 to 0.
- Stall asserted in cycle S with the slot valid: the slot is frozen from S. The read in flight goes to skid at the end of S, and there is no issue from S.
- Stall released in cycle R: skid moves to the slot at the end of R, and a new issue happens in R. No bubble after the skid drains.
- Redirect in cycle N: if_valid=0 in N+1, target issued in N+1, target presented in N+3.
- Redirect and stall in the same cycle: the redirect wins.
- Reset asserted mid-stream: all state clears immediately (asynchronous); the boot sequence repeats.

## Structure
- Package fetch_pkg:
  - XLEN=32 and INSTR_STEP=4.
  - Occupancy state enum {EMPTY, STREAM, FULL}.
  - RESET_PC default.
- Sub-module fetch_skid_buf: one-entry pc+instr holding register with load/clear. Instantiated once.
- The pc register and issue logic stay in fetch_controller.

## Test plan
- Boot: release rst, no stall, memory preloaded with words at 0, 4, 8 → if_valid rises 2 cycles after release; if_pc sequence 0, 4, 8, 12; instructions match memory.
- Stall: assert stall for 3 cycles while if_pc=8 → if_pc/if_instr hold at 8; skid captures 12; after release, 12 and 16 arrive on consecutive cycles with no bubble and no duplicate.
- Redirect: redirect=1, redirect_pc=20 while streaming at 8 → if_valid=0 the next cycle; if_pc=20 two cycles after that; the squashed word at 12 is never presented.
- Redirect during stall with skid full, target 4 → skid discarded; next presented if_pc is 4; misalign_err stays 0.
- Misaligned redirect to 0x17 → fetch from 0x14; misalign_err=1 until reset.
- Wrap and reset: stream past 28 → if_pc goes to 0. Then assert rst mid-stream → if_valid=0 and imem_en=0 immediately; boot sequence repeats from RESET_PC.
